// File: rtl/calc_pkg.sv
// Shared definitions for the calculator arbiter slice: opcodes, FSM states, default width.
package calc_pkg;

    localparam int unsigned CALC_W = 8;

    localparam logic [2:0] OP_ADD      = 3'd0;
    localparam logic [2:0] OP_SUB      = 3'd1;
    localparam logic [2:0] OP_AND      = 3'd2;
    localparam logic [2:0] OP_XOR      = 3'd3;
    localparam logic [2:0] OP_DIV      = 3'd4;
    localparam logic [2:0] OP_MUL      = 3'd5;
    localparam logic [2:0] OP_PASS     = 3'd6;
    localparam logic [2:0] OP_PASS_ALT = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    // Pass opcodes never produce done from the calculator.
    function automatic logic is_pass(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant picker; on contention the requester that did not win last time is chosen.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_grant_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/calc_arbiter.sv
// Shares one calculator between two requesters: round-robin grant, one-cycle go,
// done/timeout wait, then a valid/ready response to the winner.
module calc_arbiter
    import calc_pkg::*;
#(
    parameter int unsigned W       = CALC_W,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CW      = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [2:0]   req0_op,
    input  logic [W-1:0] req0_x,
    input  logic [W-1:0] req0_y,
    output logic         req0_ready,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    input  logic         req1_valid,
    input  logic [2:0]   req1_op,
    input  logic [W-1:0] req1_x,
    input  logic [W-1:0] req1_y,
    output logic         req1_ready,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [W-1:0] rsp_hi,
    output logic [W-1:0] rsp_lo,
    output logic         rsp_err,
    output logic         rsp_timeout,
    output logic         calc_go,
    output logic [2:0]   calc_f,
    output logic [W-1:0] calc_x,
    output logic [W-1:0] calc_y,
    input  logic         calc_done,
    input  logic [W-1:0] calc_hi,
    input  logic [W-1:0] calc_lo,
    input  logic         calc_err,
    output logic         busy
);

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    arb_state_e     state_q, state_d;
    logic           last_q, last_d;
    logic           gid_q, gid_d;
    logic [2:0]     op_q, op_d;
    logic [W-1:0]   x_q, x_d, y_q, y_d;
    logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic           err_q, err_d, to_q, to_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     gnt;

    rr_arb2 u_rr_arb2 (
        .req_i        ({req1_valid, req0_valid}),
        .last_grant_i (last_q),
        .gnt_o        (gnt)
    );

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        gid_d      = gid_q;
        op_d       = op_q;
        x_d        = x_q;
        y_d        = y_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        err_d      = err_q;
        to_d       = to_q;
        cnt_d      = cnt_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        calc_go    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (gnt != 2'b00) begin
                    gid_d      = gnt[1];
                    op_d       = gnt[1] ? req1_op : req0_op;
                    x_d        = gnt[1] ? req1_x  : req0_x;
                    y_d        = gnt[1] ? req1_y  : req0_y;
                    req0_ready = gnt[0];
                    req1_ready = gnt[1];
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                calc_go = 1'b1;
                cnt_d   = '0;
                if (is_pass(op_q)) begin
                    hi_d    = '0;
                    lo_d    = '0;
                    err_d   = 1'b0;
                    to_d    = 1'b0;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // done takes priority over a simultaneous timeout
                if (calc_done) begin
                    hi_d    = calc_hi;
                    lo_d    = calc_lo;
                    err_d   = calc_err;
                    to_d    = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    hi_d    = '0;
                    lo_d    = '0;
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (gid_q ? rsp1_ready : rsp0_ready) begin
                    last_d  = gid_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            gid_q   <= 1'b0;
            op_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
            op_q    <= op_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            err_q   <= err_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end

    assign calc_f      = op_q;
    assign calc_x      = x_q;
    assign calc_y      = y_q;
    assign rsp_hi      = hi_q;
    assign rsp_lo      = lo_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = to_q;
    assign rsp0_valid  = (state_q == ST_RESP) && !gid_q;
    assign rsp1_valid  = (state_q == ST_RESP) &&  gid_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
